// File: rtl/reset_sequencer.sv
// Reset sequencer: filters PLL lock, debounces a push-button and walks the
// per-channel resets out of assertion one at a time, waiting for each
// channel's done_in (with timeout) before releasing the next one.
//
// Ports
//   cpu_clk_g   system clock, rising edge
//   rst         synchronous active-high reset
//   btn         raw asynchronous push-button (high = pressed)
//   pll_lock    asynchronous PLL lock indicator
//   sw_rst_req  single-cycle software reset request
//   done_in     per-channel init-complete level
//   ch_rst      per-channel reset outputs, active-high
//   all_ready   RUN state with every done_in high
//   fault       sticky done_in timeout flag
//   state       0 WAIT_LOCK, 1 HOLD, 2 RELEASE, 3 RUN
module reset_sequencer #(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned SYNC_STAGES     = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned LOCK_FILTER     = 8,
    parameter int unsigned HOLD_CYCLES     = 8,
    parameter int unsigned STAGGER_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 64
) (
    input  logic              cpu_clk_g,
    input  logic              rst,
    input  logic              btn,
    input  logic              pll_lock,
    input  logic              sw_rst_req,
    input  logic [NUM_CH-1:0] done_in,
    output logic [NUM_CH-1:0] ch_rst,
    output logic              all_ready,
    output logic              fault,
    output logic [1:0]        state
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned LK_W = $clog2(LOCK_FILTER) + 1;
    localparam int unsigned HD_W = $clog2(HOLD_CYCLES) + 1;
    localparam int unsigned ST_W = $clog2(STAGGER_CYCLES) + 1;
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned IX_W = $clog2(NUM_CH) + 1;

    localparam logic [1:0] S_WAIT_LOCK = 2'd0;
    localparam logic [1:0] S_HOLD      = 2'd1;
    localparam logic [1:0] S_RELEASE   = 2'd2;
    localparam logic [1:0] S_RUN       = 2'd3;

    logic [SYNC_STAGES-1:0] btn_sync_q, btn_sync_d;
    logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
    logic                   db_level_q, db_level_d;
    logic                   db_prev_q, db_prev_d;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic [LK_W-1:0]        lock_cnt_q, lock_cnt_d;
    logic [1:0]             state_q, state_d;
    logic [HD_W-1:0]        hold_cnt_q, hold_cnt_d;
    logic [ST_W-1:0]        stag_cnt_q, stag_cnt_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic [IX_W-1:0]        ch_idx_q, ch_idx_d;
    logic                   waiting_q, waiting_d;
    logic [NUM_CH-1:0]      ch_rst_q, ch_rst_d;
    logic                   all_ready_q, all_ready_d;
    logic                   fault_q, fault_d;

    logic btn_s, lock_s, lock_ok_c, btn_evt_c, sel_done_c, restart_c;

    assign btn_s  = btn_sync_q[SYNC_STAGES-1];
    assign lock_s = lock_sync_q[SYNC_STAGES-1];

    // Lock is trusted only while the filter is full and the current sample is high.
    assign lock_ok_c = lock_s & (lock_cnt_q == LK_W'(LOCK_FILTER));
    assign btn_evt_c = db_level_q & ~db_prev_q;
    assign restart_c = btn_evt_c | sw_rst_req;

    // Synchronizers, button debounce and lock filter.
    always_comb begin
        btn_sync_d  = {btn_sync_q[SYNC_STAGES-2:0], btn};
        lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], pll_lock};
        db_level_d  = db_level_q;
        db_prev_d   = db_level_q;
        db_cnt_d    = '0;
        lock_cnt_d  = '0;
        if (btn_s != db_level_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_level_d = btn_s;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
        if (lock_s) begin
            lock_cnt_d = (lock_cnt_q == LK_W'(LOCK_FILTER)) ? lock_cnt_q
                                                             : lock_cnt_q + LK_W'(1);
        end
    end

    // Sequencer next-state and output logic.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        stag_cnt_d  = stag_cnt_q;
        to_cnt_d    = to_cnt_q;
        ch_idx_d    = ch_idx_q;
        waiting_d   = waiting_q;
        ch_rst_d    = ch_rst_q;
        fault_d     = fault_q;
        sel_done_c  = 1'b0;

        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_idx_q == IX_W'(i)) sel_done_c = done_in[i];
        end

        case (state_q)
            S_WAIT_LOCK: begin
                if (lock_ok_c) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = '0;
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == HD_W'(HOLD_CYCLES - 1)) begin
                    state_d    = S_RELEASE;
                    ch_idx_d   = '0;
                    waiting_d  = 1'b0;
                    stag_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HD_W'(1);
                end
            end
            S_RELEASE: begin
                if (!waiting_q) begin
                    if (stag_cnt_q == ST_W'(STAGGER_CYCLES - 1)) begin
                        for (int unsigned i = 0; i < NUM_CH; i++) begin
                            if (ch_idx_q == IX_W'(i)) ch_rst_d[i] = 1'b0;
                        end
                        waiting_d = 1'b1;
                        to_cnt_d  = '0;
                    end else begin
                        stag_cnt_d = stag_cnt_q + ST_W'(1);
                    end
                end else if (sel_done_c || to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    // A timeout is flagged, then treated like a completed channel.
                    if (!sel_done_c) fault_d = 1'b1;
                    if (ch_idx_q == IX_W'(NUM_CH - 1)) begin
                        state_d = S_RUN;
                    end else begin
                        ch_idx_d   = ch_idx_q + IX_W'(1);
                        waiting_d  = 1'b0;
                        stag_cnt_d = '0;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: ;
        endcase

        // Lock loss outranks a button/software restart.
        if (state_q != S_WAIT_LOCK && !lock_ok_c) begin
            state_d = S_WAIT_LOCK;
        end else if (state_q != S_WAIT_LOCK && restart_c) begin
            state_d    = S_HOLD;
            hold_cnt_d = '0;
        end

        if (state_d == S_WAIT_LOCK || state_d == S_HOLD) begin
            ch_rst_d  = '1;
            ch_idx_d  = '0;
            waiting_d = 1'b0;
        end

        all_ready_d = (state_d == S_RUN) && (&done_in);
    end

    always_ff @(posedge cpu_clk_g) begin
        if (rst) begin
            btn_sync_q  <= '0;
            lock_sync_q <= '0;
            db_level_q  <= 1'b0;
            db_prev_q   <= 1'b0;
            db_cnt_q    <= '0;
            lock_cnt_q  <= '0;
            state_q     <= S_WAIT_LOCK;
            hold_cnt_q  <= '0;
            stag_cnt_q  <= '0;
            to_cnt_q    <= '0;
            ch_idx_q    <= '0;
            waiting_q   <= 1'b0;
            ch_rst_q    <= '1;
            all_ready_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            btn_sync_q  <= btn_sync_d;
            lock_sync_q <= lock_sync_d;
            db_level_q  <= db_level_d;
            db_prev_q   <= db_prev_d;
            db_cnt_q    <= db_cnt_d;
            lock_cnt_q  <= lock_cnt_d;
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            stag_cnt_q  <= stag_cnt_d;
            to_cnt_q    <= to_cnt_d;
            ch_idx_q    <= ch_idx_d;
            waiting_q   <= waiting_d;
            ch_rst_q    <= ch_rst_d;
            all_ready_q <= all_ready_d;
            fault_q     <= fault_d;
        end
    end

    assign ch_rst    = ch_rst_q;
    assign all_ready = all_ready_q;
    assign fault     = fault_q;
    assign state     = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default 4-channel instance plus a
// 1-channel / HOLD_CYCLES=1 instance.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst, btn, pll_lock, sw_rst_req;
    logic [3:0] done_in, ch_rst;
    logic       all_ready, fault;
    logic [1:0] state;

    logic       rst1, btn1, lock1, sw1;
    logic [0:0] done1, ch_rst1;
    logic       all_ready1, fault1;
    logic [1:0] state1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reset_sequencer u_dut (
        .cpu_clk_g(clk), .rst(rst), .btn(btn), .pll_lock(pll_lock),
        .sw_rst_req(sw_rst_req), .done_in(done_in), .ch_rst(ch_rst),
        .all_ready(all_ready), .fault(fault), .state(state)
    );

    reset_sequencer #(.NUM_CH(1), .HOLD_CYCLES(1)) u_dut1 (
        .cpu_clk_g(clk), .rst(rst1), .btn(btn1), .pll_lock(lock1),
        .sw_rst_req(sw1), .done_in(done1), .ch_rst(ch_rst1),
        .all_ready(all_ready1), .fault(fault1), .state(state1)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [1:0] exp, input int budget, input string tag);
        int n;
        n = 0;
        while (state !== exp && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, 32'(state), 32'(exp));
    endtask

    initial begin
        int n;
        rst = 1'b1; btn = 1'b0; pll_lock = 1'b0; sw_rst_req = 1'b0; done_in = 4'hF;
        rst1 = 1'b1; btn1 = 1'b0; lock1 = 1'b0; sw1 = 1'b0; done1 = 1'b1;
        tick(3);

        // Reset state
        check("rst_state", 32'(state), 32'd0);
        check("rst_ch_rst", 32'(ch_rst), 32'hF);
        check("rst_all_ready", 32'(all_ready), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);

        // Power-up with lock present: 3 sync + 8 filter + 1 transition edge
        rst = 1'b0; pll_lock = 1'b1;
        n = 0;
        while (state !== 2'd1 && n < 40) begin
            tick(1);
            n++;
        end
        check("hold_entry_cycle", 32'(n), 32'd12);
        check("hold_ch_rst", 32'(ch_rst), 32'hF);
        tick(11);
        check("ch0_before_release", 32'(ch_rst), 32'hF);
        tick(1);
        check("ch0_release", 32'(ch_rst), 32'hE);
        tick(4);
        check("ch1_before", 32'(ch_rst), 32'hE);
        tick(1);
        check("ch1_release", 32'(ch_rst), 32'hC);
        tick(5);
        check("ch2_release", 32'(ch_rst), 32'h8);
        tick(5);
        check("ch3_release", 32'(ch_rst), 32'h0);
        check("still_release", 32'(state), 32'd2);
        tick(1);
        check("run_state", 32'(state), 32'd3);
        check("run_all_ready", 32'(all_ready), 32'd1);

        // done_in drop in RUN only affects all_ready
        done_in = 4'b1011;
        tick(1);
        check("done_drop_ready", 32'(all_ready), 32'd0);
        check("done_drop_state", 32'(state), 32'd3);
        done_in = 4'hF;
        tick(1);
        check("done_back_ready", 32'(all_ready), 32'd1);

        // One-cycle lock loss
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        tick(2);
        check("lockloss_pending", 32'(state), 32'd3);
        tick(1);
        check("lockloss_state", 32'(state), 32'd0);
        check("lockloss_ch_rst", 32'(ch_rst), 32'hF);
        check("lockloss_ready", 32'(all_ready), 32'd0);
        wait_state(2'd1, 30, "relock_hold");
        wait_state(2'd3, 100, "relock_run");
        check("relock_ch_rst", 32'(ch_rst), 32'h0);
        tick(1);
        check("relock_ready", 32'(all_ready), 32'd1);

        // Software request coincident with lock loss: lock loss wins
        pll_lock = 1'b0;
        tick(3);
        check("coinc_pre", 32'(state), 32'd3);
        sw_rst_req = 1'b1;
        tick(1);
        sw_rst_req = 1'b0;
        check("coinc_state", 32'(state), 32'd0);
        check("coinc_ch_rst", 32'(ch_rst), 32'hF);
        pll_lock = 1'b1;
        wait_state(2'd3, 150, "coinc_recover_run");

        // Button glitch shorter than debounce window
        btn = 1'b1;
        tick(10);
        btn = 1'b0;
        tick(30);
        check("glitch_state", 32'(state), 32'd3);
        check("glitch_ch_rst", 32'(ch_rst), 32'h0);

        // Button held long enough: 3 sync + 16 debounce + 1 transition edge
        btn = 1'b1;
        tick(19);
        check("btn_pre", 32'(state), 32'd3);
        tick(1);
        check("btn_state", 32'(state), 32'd1);
        check("btn_ch_rst", 32'(ch_rst), 32'hF);
        btn = 1'b0;
        wait_state(2'd3, 200, "btn_recover_run");

        // Software request in RUN
        sw_rst_req = 1'b1;
        tick(1);
        sw_rst_req = 1'b0;
        check("sw_state", 32'(state), 32'd1);
        check("sw_ch_rst", 32'(ch_rst), 32'hF);

        // done_in[1] stuck low: timeout 64 cycles after ch_rst[1] falls
        done_in = 4'b1101;
        n = 0;
        while (ch_rst[1] !== 1'b0 && n < 100) begin
            tick(1);
            n++;
        end
        check("to_ch1_fell", 32'(ch_rst), 32'hC);
        tick(63);
        check("to_fault_pre", 32'(fault), 32'd0);
        tick(1);
        check("to_fault", 32'(fault), 32'd1);
        tick(3);
        check("to_ch2_pre", 32'(ch_rst), 32'hC);
        tick(1);
        check("to_ch2_fell", 32'(ch_rst), 32'h8);
        wait_state(2'd3, 30, "to_run");
        tick(1);
        check("to_run_ready", 32'(all_ready), 32'd0);
        sw_rst_req = 1'b1;
        tick(1);
        sw_rst_req = 1'b0;
        check("fault_sticky", 32'(fault), 32'd1);

        // Reset mid-RELEASE, together with a software request
        done_in = 4'hF;
        n = 0;
        while (ch_rst !== 4'hC && n < 60) begin
            tick(1);
            n++;
        end
        check("mid_release_state", 32'(state), 32'd2);
        rst = 1'b1; sw_rst_req = 1'b1;
        tick(1);
        rst = 1'b0; sw_rst_req = 1'b0;
        check("midrst_ch_rst", 32'(ch_rst), 32'hF);
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_fault", 32'(fault), 32'd0);
        check("midrst_ready", 32'(all_ready), 32'd0);

        // Single channel, HOLD_CYCLES=1
        rst1 = 1'b0; lock1 = 1'b1;
        n = 0;
        while (state1 !== 2'd1 && n < 30) begin
            tick(1);
            n++;
        end
        check("c1_hold", 32'(state1), 32'd1);
        tick(4);
        check("c1_ch_pre", 32'(ch_rst1), 32'd1);
        tick(1);
        check("c1_ch_rel", 32'(ch_rst1), 32'd0);
        tick(1);
        check("c1_run", 32'(state1), 32'd3);
        check("c1_ready", 32'(all_ready1), 32'd1);
        check("c1_fault", 32'(fault1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_CH, default 4: number of reset channels, 1..8.
REQ-002 Parameter SYNC_STAGES, default 3: synchronizer depth for btn and pll_lock, >=2.
REQ-003 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable samples required to accept a btn level.
REQ-004 Parameter LOCK_FILTER, default 8: consecutive high samples required to accept pll_lock.
REQ-005 Parameter HOLD_CYCLES, default 8: minimum all-channel assertion time.
REQ-006 Parameter STAGGER_CYCLES, default 4: delay before each channel release.
REQ-007 Parameter TIMEOUT_CYCLES, default 64: per-channel done wait limit.
REQ-008 cpu_clk_g  in  1  system clock; all logic on its rising edge.
REQ-009 rst  in  1  reset, synchronous, active-high.
REQ-010 btn  in  1  raw asynchronous push-button, high = pressed.
REQ-011 pll_lock  in  1  asynchronous PLL lock indicator.
REQ-012 sw_rst_req  in  1  synchronous single-cycle software reset request.
REQ-013 done_in  in  NUM_CH  per-channel init-complete, synchronous, level.
REQ-014 ch_rst  out  NUM_CH  per-channel reset, active-high, registered.
REQ-015 all_ready  out  1  registered; high only in RUN with all done_in high.
REQ-016 fault  out  1  sticky done_in timeout flag, registered.
REQ-017 state  out  2  current FSM state: 0 WAIT_LOCK, 1 HOLD, 2 RELEASE, 3 RUN.

Function
REQ-018 btn and pll_lock each SHALL pass through SYNC_STAGES flops before any use.
REQ-019 Debounced button level SHALL change only after the synchronized btn differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free sample resets the count.
REQ-020 Button event SHALL be the single-cycle rising edge of the debounced level.
REQ-021 lock_ok SHALL rise after LOCK_FILTER consecutive high synchronized samples and fall in the same cycle the synchronized sample is low.
REQ-022 WAIT_LOCK: ch_rst all ones; go to HOLD when lock_ok high.
REQ-023 HOLD: ch_rst all ones; counter runs HOLD_CYCLES cycles, then go to RELEASE with channel index 0.
REQ-024 RELEASE: ch_rst[i] SHALL deassert STAGGER_CYCLES cycles after RELEASE entry (i=0) or after done_in[i-1] is sampled high (i>0); channels release strictly in ascending index order.
REQ-025 After ch_rst[i] deasserts, a timeout counter SHALL run; if done_in[i] is not high within TIMEOUT_CYCLES cycles, fault SHALL set and sequencing proceeds as if done_in[i] were high.
REQ-026 When done_in[NUM_CH-1] is sampled high (or times out), go to RUN.
REQ-027 all_ready SHALL equal (state==RUN) AND all done_in high, registered one cycle later.
REQ-028 Lock loss (lock_ok low) in any state other than WAIT_LOCK SHALL go to WAIT_LOCK and assert all ch_rst on the next cycle.
REQ-029 Button event or sw_rst_req in HOLD, RELEASE or RUN SHALL go to HOLD, restart the hold counter, and assert all ch_rst on the next cycle.
REQ-030 Simultaneous lock loss and button/software request: lock loss wins.
REQ-031 Channels already released SHALL never re-deassert out of order; re-entry to HOLD always restarts from channel 0.
REQ-032 done_in deasserting in RUN SHALL drop all_ready only; no state change.
REQ-033 fault SHALL clear only on rst.
REQ-034 All counters SHALL saturate, never wrap; widths sized by $clog2 of their parameter + 1.

Reset
REQ-035 On rst: state=WAIT_LOCK, ch_rst all ones, all_ready=0, fault=0, all counters, synchronizer and debounce flops zero; rst overrides every event in the same cycle.
REQ-036 rst asserted mid-RELEASE SHALL re-assert all released channels on the following edge.

Verification
REQ-037 Defaults, pll_lock high from cycle 0 -> state HOLD at cycle 3+8=11 (±1), ch_rst[0] low 8+4 cycles later; done_in tied high -> ch_rst 4'b0000 and all_ready=1 after four 4-cycle staggers.
REQ-038 RUN, pll_lock low one cycle -> within SYNC_STAGES+1 cycles ch_rst=4'b1111, state=0, all_ready=0; relock repeats full sequence.
REQ-039 btn glitch high 10 cycles -> no change; btn high 20 cycles -> HOLD entered, ch_rst=4'b1111.
REQ-040 done_in[1] stuck low -> fault=1 exactly 64 cycles after ch_rst[1] falls; ch_rst[2] falls 4 cycles later; fault persists until rst.
REQ-041 sw_rst_req pulse on same cycle as lock loss -> state=WAIT_LOCK, not HOLD.
REQ-042 NUM_CH=1, HOLD_CYCLES=1 -> sequence completes; ch_rst 1-bit releases after HOLD+STAGGER.
